// File: rtl/arm_io_pkg.sv
// Shared constants for the ARM-core I/O peripherals.
// Holds the switch width and the default debounce/FIFO sizing.
package arm_io_pkg;
    localparam int SW_WIDTH            = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int FIFO_DEPTH_DEF      = 4;
endpackage

// File: rtl/sw_event_fifo.sv
// Event FIFO for debounced switch values.
// Registered pop output with a one-cycle valid pulse; pushes are dropped only when full without a pop.
module sw_event_fifo
    import arm_io_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = SW_WIDTH
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_do_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
endmodule

// File: rtl/sw_input_port.sv
// Switch input port: synchronizes and debounces SW, queues each accepted value
// as an event for the core, and flags events dropped on a full queue.
module sw_input_port
    import arm_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] SW,
    input  logic                rd_en,
    input  logic                clr_ovf,
    output logic [SW_WIDTH-1:0] rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    output logic                irq
);
    logic [SW_WIDTH-1:0] r_s1;
    logic [SW_WIDTH-1:0] r_s2;
    logic [SW_WIDTH-1:0] r_stable;
    logic [7:0]          r_cnt;
    logic                r_overflow;

    logic [7:0] w_cnt_inc;
    logic [7:0] w_cnt_next;
    logic       w_accept;
    logic       w_drop;
    logic       w_full;
    logic       w_empty;

    // s2 is about to change when s1 differs from it, which restarts the count.
    always_comb begin
        w_cnt_inc  = r_cnt + 8'd1;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        if ((r_s2 == r_stable) || (r_s1 != r_s2)) begin
            w_cnt_next = '0;
        end else if (w_cnt_inc == 8'(DEBOUNCE_CYCLES)) begin
            w_cnt_next = '0;
            w_accept   = 1'b1;
        end else begin
            w_cnt_next = w_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_s1  <= SW;
            r_s2  <= r_s1;
            r_cnt <= w_cnt_next;
            if (w_accept) begin
                r_stable <= r_s2;
            end
        end
    end

    assign w_drop = w_accept && w_full && !(rd_en && !w_empty);

    // A drop on the same edge as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    sw_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SW_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .i_rst      (rst),
        .i_push     (w_accept),
        .i_wdata    (r_s2),
        .i_pop      (rd_en),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign irq      = !w_empty;
endmodule

// File: doc/sw_input_port.md
SW_INPUT_PORT -- requirements
Module: sw_input_port

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles (legal range 1..255) required to accept a new SW value.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries (power of two, at least 2).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-005 Port SW SHALL be an input, 8 bits: raw asynchronous switch inputs.
REQ-006 Port rd_en SHALL be an input, 1 bit: the core requests a pop of the oldest event.
REQ-007 Port clr_ovf SHALL be an input, 1 bit: clears the overflow flag.
REQ-008 Port rd_data SHALL be an output, 8 bits: the popped debounced SW value.
REQ-009 Port rd_valid SHALL be an output, 1 bit: a one-cycle pulse meaning rd_data holds a newly popped value.
REQ-010 Ports empty and full SHALL be outputs, 1 bit each: FIFO status.
REQ-011 Port overflow SHALL be an output, 1 bit: sticky flag set when an event is dropped.
REQ-012 Port irq SHALL be an output, 1 bit: equal to not empty.

Function
REQ-013 SW SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-014 The debounce counter SHALL clear whenever s2 equals the stable value, or whenever s2 differs from its value at the previous edge.
REQ-015 Otherwise the debounce counter SHALL increment by 1 per edge.
REQ-016 When the counter reaches DEBOUNCE_CYCLES, the stable value SHALL load s2, the counter SHALL clear, and one event holding s2 SHALL be pushed, all on the same edge.
REQ-017 If SW first changes at edge N and then holds, empty SHALL deassert after edge N+DEBOUNCE_CYCLES+1 (edge N+5 at default).
REQ-018 A pulse held for DEBOUNCE_CYCLES cycles or less, or a value that reverts before acceptance, SHALL produce no event.
REQ-019 rd_en while not empty SHALL pop the oldest entry: rd_data updates and rd_valid is 1 in the following cycle.
REQ-020 rd_en while empty SHALL be ignored: rd_data holds its value and rd_valid stays 0.
REQ-021 rd_data SHALL hold its last popped value until the next accepted pop.
REQ-022 A push while full, without a simultaneous pop, SHALL drop the new event and set overflow; FIFO contents SHALL be unchanged.
REQ-023 A simultaneous push and pop SHALL both be accepted, including when full or when empty-then-push; the occupancy count SHALL be unchanged, except when empty, where the pop is ignored and the count becomes 1.
REQ-024 clr_ovf SHALL clear overflow at the next edge; if a drop occurs on the same edge, overflow SHALL remain 1 (set wins).
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 The occupancy count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-027 full SHALL be 1 when count equals FIFO_DEPTH; empty SHALL be 1 when count equals 0.

Reset
REQ-028 While rst=1, at each edge: s1, s2, stable value and counter SHALL be set to 0; the FIFO SHALL be emptied; rd_data SHALL be set to 0x00; rd_valid, overflow and full SHALL be set to 0; empty SHALL be set to 1.
REQ-029 A reset asserted mid-debounce or mid-read SHALL discard all pending state; a rd_valid pulse due in the following cycle SHALL be suppressed.
REQ-030 After reset, a nonzero SW that holds long enough SHALL generate a normal event, because the stable value resets to 0.

Structure
REQ-031 The shared package arm_io_pkg SHALL hold SW_WIDTH=8 and the default constants DEBOUNCE_CYCLES_DEF=4 and FIFO_DEPTH_DEF=4.
REQ-032 The FIFO SHALL be the sub-module sw_event_fifo, containing the storage, pointers, count, full and empty.
REQ-033 Synchronizer, debounce logic and overflow flag SHALL reside in sw_input_port.

Verification
REQ-034 Reset, then set SW to 0x02 and hold 10 cycles: empty falls after edge N+5; rd_en for 1 cycle; next cycle rd_data=0x02, rd_valid=1; then empty=1 and irq=0.
REQ-035 SW=0x04 for 3 cycles, then 0x00: no event, empty stays 1.
REQ-036 Apply 5 stable changes 0x01, 0x02, 0x03, 0x02, 0x00 with no reads: full=1 after the 4th; overflow=1 after the 5th; the pops return 0x01, 0x02, 0x03, 0x02.
REQ-037 FIFO full, and rd_en arrives on the push edge of a new value 0x07: overflow stays 0; count stays 4; 0x07 is popped last.
REQ-038 rd_en with FIFO empty: rd_valid=0 and rd_data is unchanged; then clr_ovf after an overflow clears overflow to 0.
REQ-039 rst asserted while the debounce counter is at 3: after release, SW held at 0x02 yields exactly one event 0x02 after the full latency.
